ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It sits directly downstream of the ID/EX pipeline register.
- Consumes instrE, rs1_dataE and rs2_dataE.
- Raises a stall into the hazard logic that drives StallE/StallD while an M-extension operation is executing.
- Delivers a 32-bit result to the EX result mux on completion.

---
 rtl/ex_muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use radix-2 shift-add and divides use restoring division.
// Both share one 64-bit accumulator and take one step per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in a single cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    input  logic            i_hold,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   b_q;      // multiplicand or divisor magnitude
    logic [2:0]        op_q;
    logic              neg_q;    // product / quotient sign
    logic              rneg_q;   // remainder sign follows rs1

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic            is_mop;
    logic [2:0]      op;
    logic            a_sgn_op;
    logic            b_sgn_op;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    assign is_mop   = (i_instr[6:0] == 7'b0110011) && (i_instr[31:25] == 7'b0000001);
    assign op       = i_instr[14:12];
    assign a_sgn_op = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign b_sgn_op = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign sa       = a_sgn_op & i_rs1[XLEN-1];
    assign sb       = b_sgn_op & i_rs2[XLEN-1];
    assign a_mag    = sa ? -i_rs1 : i_rs1;
    assign b_mag    = sb ? -i_rs2 : i_rs2;

    // Divide corner cases resolve without iterating
    assign div_zero    = op[2] && (i_rs2 == '0);
    assign div_ovf     = op[2] && !op[0] && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    assign special_res = div_zero ? (op[1] ? i_rs1 : '1) : (op[1] ? '0 : 32'h8000_0000);

    assign o_stall = !i_rst && is_mop && !i_flush && (state != DONE);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa;
    logic signed [XLEN:0]     fb;
    logic signed [2*XLEN+1:0] fprod;
    logic [XLEN-1:0]          fast_res;
    logic                     unused_fast;

    assign fa          = $signed({a_sgn_op & i_rs1[XLEN-1], i_rs1});
    assign fb          = $signed({b_sgn_op & i_rs2[XLEN-1], i_rs2});
    assign fprod       = fa * fb;
    assign fast_res    = (op[1:0] == 2'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    assign unused_fast = ^fprod[2*XLEN+1:2*XLEN];
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fin_res;
    logic              unused_bits;

    assign unused_bits = ^{i_instr[24:15], i_instr[11:7], div_diff[XLEN]};

    // One shift-add or restore step, plus sign fixup of the final step's result
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_trial - {1'b0, b_q};
        div_ge    = div_trial >= {1'b0, b_q};
        if (op_q[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]), acc[XLEN-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_dw(acc_step, neg_q);
        if (!op_q[2]) begin
            fin_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            fin_res = neg_w(acc_step[2*XLEN-1:XLEN], rneg_q);
        end else begin
            fin_res = neg_w(acc_step[XLEN-1:0], neg_q);
        end
    end

    // Control FSM: start/special-case in IDLE, iterate in BUSY, present result in DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else if (i_flush) begin
            state   <= IDLE;
            cnt     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mop) begin
                        acc    <= {{XLEN{1'b0}}, a_mag};
                        b_q    <= b_mag;
                        op_q   <= op;
                        neg_q  <= sa ^ sb;
                        rneg_q <= sa;
                        cnt    <= '0;
                        if (div_zero || div_ovf) begin
                            state    <= DONE;
                            o_valid  <= 1'b1;
                            o_result <= special_res;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!op[2]) begin
                            state    <= DONE;
                            o_valid  <= 1'b1;
                            o_result <= fast_res;
                        end
`endif
                        else begin
                            state  <= BUSY;
                            o_busy <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        state    <= DONE;
                        o_busy   <= 1'b0;
                        o_valid  <= 1'b1;
                        o_result <= fin_res;
                    end
                end
                DONE: begin
                    if (!i_hold) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed bench for ex_muldiv_unit with a transaction-level
// reference model checked every cycle, plus hand-computed expectations.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        hold;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_instr (instr),
        .i_rs1   (rs1),
        .i_rs2   (rs2),
        .i_flush (flush),
        .i_hold  (hold),
        .o_stall (stall),
        .o_busy  (busy),
        .o_valid (valid),
        .o_result(result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_m(input logic [2:0] f);
        return {7'b0000001, 5'd2, 5'd1, f, 5'd3, 7'b0110011};
    endfunction

    function automatic bit tb_is_mop(input logic [31:0] ins);
        return (ins[6:0] == 7'h33) && (ins[31:25] == 7'h01);
    endfunction

    // RV32M result rules in plain 64-bit arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (!f[2]) return MUL_LAT;
        return 33;
    endfunction

    // Model: cycles since the op was accepted, its latency, and the expected result
    int          m_cyc = -1;
    int          m_lat = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_result = 32'h0;
    logic [31:0] m_pend = 32'h0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        int          c;
        int          l;
        logic        v;
        logic [31:0] r;
        logic [31:0] p;
        c = m_cyc; l = m_lat; v = m_valid; r = m_result; p = m_pend;
        if (rst) begin
            c = -1; v = 1'b0; r = 32'h0;
        end else if (flush) begin
            c = -1; v = 1'b0;
        end else if (c < 0) begin
            if (tb_is_mop(instr)) begin
                l = ref_lat(instr[14:12], rs1, rs2);
                p = ref_mdu(instr[14:12], rs1, rs2);
                c = 1;
                if (l == 1) begin v = 1'b1; r = p; end
            end
        end else if (c < l) begin
            c = c + 1;
            if (c == l) begin v = 1'b1; r = p; end
        end else if (!hold) begin
            c = -1; v = 1'b0;
        end
        m_cyc <= c; m_lat <= l; m_valid <= v; m_result <= r; m_pend <= p;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_stall", {31'b0, stall},
                {31'b0, (!rst && tb_is_mop(instr) && !flush && !(m_cyc >= 0 && m_cyc == m_lat))});
            chk("cyc_busy", {31'b0, busy}, {31'b0, (m_cyc >= 1 && m_cyc < m_lat)});
            chk("cyc_valid", {31'b0, valid}, {31'b0, m_valid});
            chk("cyc_result", result, m_result);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        chk({nm, "_model"}, ref_mdu(f, a, b), exp);
        @(posedge clk); #1;
        instr = mk_m(f); rs1 = a; rs2 = b;
        n = 0;
        while (valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            rs1 = $urandom; rs2 = $urandom;
        end
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_res"}, result, exp);
        @(posedge clk); #1;
        instr = NOP;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcnt;
        rst = 1'b1; flush = 1'b0; hold = 1'b0; instr = mk_m(3'd0); rs1 = 32'd7; rs2 = 32'd3;
        #2;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        instr = NOP;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_result", result, 32'd0);

        // Non-M R-type instruction does nothing
        instr = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        #1;
        chk("nonm_stall", {31'b0, stall}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("nonm_busy", {31'b0, busy}, 32'd0);
        instr = NOP;

        run_op("mul_neg",   3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divu_z",    3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("div_z",     3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",     3'd6, 32'd5,         32'd0,         32'h0000_0005, 1);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("remu",      3'd7, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu",      3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("divu_max",  3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);

        // Flush mid-divide: no result, then a fresh multiply
        @(posedge clk); #1;
        instr = mk_m(3'd5); rs1 = 32'd100; rs2 = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; instr = NOP;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_valid", {31'b0, valid}, 32'd0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) vcnt++;
        end
        chk("flush_novalid", vcnt, 0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT);

        // Hold in DONE for three cycles
        @(posedge clk); #1;
        instr = mk_m(3'd0); rs1 = 32'd3; rs2 = 32'd4;
        n = 0;
        while (valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("hold_lat", n, MUL_LAT);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", {31'b0, valid}, 32'd1);
            chk("hold_res", result, 32'd12);
            chk("hold_stall", {31'b0, stall}, 32'd0);
            if (i == 3) hold = 1'b0;
            @(posedge clk); #1;
        end
        chk("hold_release", {31'b0, valid}, 32'd0);
        instr = NOP;

        // Reset in the middle of a divide
        @(posedge clk); #1;
        instr = mk_m(3'd4); rs1 = 32'd100; rs2 = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; instr = NOP;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) vcnt++;
        end
        chk("midrst_novalid", vcnt, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
